// File: rtl/iobuf_bus_sequencer.sv
// rtl/iobuf_bus_sequencer.sv - half-duplex pad-buffer transaction sequencer
//
// Turns a valid/ready request stream into pad-buffer bus cycles with a shared
// tristate control. Writes drive pad_i with pad_t low. Reads release the bus,
// strobe the device and capture pad_o. Every transaction is followed by
// released-bus turnaround cycles, so two drivers never overlap on the pads.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_write selects write (1) or read (0)
//   req_wdata            write data, latched on accept
//   rsp_valid/rsp_ready  read-response handshake; rsp_rdata holds captured pad_o
//   pad_i, pad_t, pad_o  pad-buffer I / T (1 = released) / O
//   bus_stb, bus_wr      device strobe and direction qualifier
module iobuf_bus_sequencer #(
  parameter int WIDTH        = 8,
  parameter int DRIVE_CYCLES = 2,
  parameter int SAMPLE_DELAY = 2,
  parameter int TURN_CYCLES  = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0] pad_i,
  output logic             pad_t,
  input  logic [WIDTH-1:0] pad_o,
  output logic             bus_stb,
  output logic             bus_wr
);

  localparam int MAX_DS = (DRIVE_CYCLES > SAMPLE_DELAY) ? DRIVE_CYCLES : SAMPLE_DELAY;
  localparam int MAXP   = (MAX_DS > TURN_CYCLES) ? MAX_DS : TURN_CYCLES;
  localparam int CW     = (MAXP < 1) ? 1 : $clog2(MAXP + 1);

  // The counter holds "cycles remaining after this one", so each phase loads N-1.
  localparam logic [CW-1:0] D_LOAD = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] S_LOAD = CW'(SAMPLE_DELAY - 1);
  localparam logic [CW-1:0] T_LOAD = CW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_RESP,
    ST_TURN
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          accept;

  // While nRST is low the state register already reads IDLE, so ready is
  // additionally gated by reset to keep requests from being accepted.
  assign req_ready = (state == ST_IDLE) && nRST;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_write) begin
            state_next = ST_DRIVE;
            cnt_next   = D_LOAD;
          end else begin
            state_next = ST_SAMPLE;
            cnt_next   = S_LOAD;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
          state_next = ST_TURN;
          cnt_next   = T_LOAD;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (cnt == '0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_TURN;
          cnt_next   = T_LOAD;
        end
      end
      ST_TURN: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pad and bus controls are registered from the next state, so they change
  // cleanly on the clock edge together with the state itself.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pad_t     <= 1'b1;
      pad_i     <= '0;
      bus_stb   <= 1'b0;
      bus_wr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pad_t     <= (state_next != ST_DRIVE);
      bus_stb   <= (state_next == ST_DRIVE) || (state_next == ST_SAMPLE);
      bus_wr    <= (state_next == ST_DRIVE);
      rsp_valid <= (state_next == ST_RESP);
      // pad_i doubles as the write-data latch and keeps its value between writes.
      if (accept && req_write) begin
        pad_i <= req_wdata;
      end
      if ((state == ST_SAMPLE) && (cnt == '0)) begin
        rsp_rdata <= pad_o;
      end
    end
  end

endmodule

// File: tb/tb_iobuf_bus_sequencer.sv
// tb/tb_iobuf_bus_sequencer.sv - self-checking bench for iobuf_bus_sequencer
module tb_iobuf_bus_sequencer;

  localparam int W = 8;
  localparam int D = 2;
  localparam int S = 2;
  localparam int T = 1;

  logic         CLK = 1'b0;
  logic         nRST = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [W-1:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_rdata;
  logic [W-1:0] pad_i;
  logic         pad_t;
  logic [W-1:0] pad_o = '0;
  logic         bus_stb;
  logic         bus_wr;

  iobuf_bus_sequencer #(
    .WIDTH(W), .DRIVE_CYCLES(D), .SAMPLE_DELAY(S), .TURN_CYCLES(T)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .pad_i(pad_i), .pad_t(pad_t), .pad_o(pad_o),
    .bus_stb(bus_stb), .bus_wr(bus_wr)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    report(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    report(name, {24'd0, act}, {24'd0, exp});
  endtask

  // Timeline model: a transaction is described by its accept cycle t0 and, for
  // reads, the cycle hs in which the response handshake happened. Every output
  // of a cycle is derived from the distance to those cycles.
  int           cyc = 0;
  int           kind = 0;        // 0 idle, 1 write in flight, 2 read in flight
  int           t0 = 0;
  int           hs = -1;
  logic [W-1:0] m_pad_i = '0;
  logic [W-1:0] m_rdata = '0;
  logic         e_ready, e_t, e_stb, e_wr, e_rv;
  logic         chk_en = 1'b0;

  task automatic model_reset();
    kind    = 0;
    hs      = -1;
    m_pad_i = '0;
    m_rdata = '0;
  endtask

  task automatic model_expect();
    int k;
    k       = cyc - t0;
    e_ready = 1'b0;
    e_t     = 1'b1;
    e_stb   = 1'b0;
    e_wr    = 1'b0;
    e_rv    = 1'b0;
    if (kind == 0) begin
      e_ready = 1'b1;
    end else if (kind == 1) begin
      if (k >= 1 && k <= D) begin
        e_t   = 1'b0;
        e_stb = 1'b1;
        e_wr  = 1'b1;
      end
    end else begin
      if (k >= 1 && k <= S) e_stb = 1'b1;
      else if (k > S && hs < 0) e_rv = 1'b1;
    end
  endtask

  // Called at the edge that ends cycle cyc, with that cycle's inputs still applied.
  task automatic model_update();
    int k;
    k = cyc - t0;
    if (kind == 0) begin
      if (req_valid) begin
        t0   = cyc;
        hs   = -1;
        kind = req_write ? 1 : 2;
        if (req_write) m_pad_i = req_wdata;
      end
    end else if (kind == 1) begin
      if (k == D + T) kind = 0;
    end else begin
      if (k == S) m_rdata = pad_o;
      if (hs < 0 && k > S && rsp_ready) hs = cyc;
      else if (hs >= 0 && cyc == hs + T) kind = 0;
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en && nRST) begin
      chk1("req_ready", req_ready, e_ready);
      chk1("pad_t", pad_t, e_t);
      chk1("bus_stb", bus_stb, e_stb);
      chk1("rsp_valid", rsp_valid, e_rv);
      if (e_stb) chk1("bus_wr", bus_wr, e_wr);
      if (!e_t) chk8("pad_i", pad_i, m_pad_i);
      if (e_rv) chk8("rsp_rdata", rsp_rdata, m_rdata);
    end
  end

  task automatic step(input logic v, input logic w, input logic [W-1:0] wd,
                      input logic rr, input logic [W-1:0] po);
    @(posedge CLK);
    model_update();
    cyc++;
    #1;
    req_valid = v;
    req_write = w;
    req_wdata = wd;
    rsp_ready = rr;
    pad_o     = po;
    model_expect();
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  // Asserts reset a few time units into the current cycle and checks the
  // outputs before any clock edge, then releases it mid-way through the next cycle.
  task automatic async_reset(input string tag);
    req_valid = 1'b0;
    #2;
    nRST   = 1'b0;
    chk_en = 1'b0;
    #1;
    chk1({tag, "_pad_t"}, pad_t, 1'b1);
    chk1({tag, "_bus_stb"}, bus_stb, 1'b0);
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk1({tag, "_req_ready"}, req_ready, 1'b0);
    chk8({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
    model_reset();
    @(posedge CLK);
    #2;
    nRST = 1'b1;
    model_expect();
    chk_en = 1'b1;
  endtask

  initial begin
    #1;
    async_reset("rst0");
    chk8("rst0_pad_i", pad_i, 8'h00);

    // Write 0xA5
    step(1, 1, 8'hA5, 0, 8'h00);
    step(0, 0, 8'h00, 0, 8'h00); settle();
    chk1("wr_c1_pad_t", pad_t, 1'b0); chk8("wr_c1_pad_i", pad_i, 8'hA5); chk1("wr_c1_bus_wr", bus_wr, 1'b1);
    step(0, 0, 8'h00, 0, 8'h00); settle();
    chk1("wr_c2_pad_t", pad_t, 1'b0); chk8("wr_c2_pad_i", pad_i, 8'hA5);
    step(0, 0, 8'h00, 0, 8'h00); settle();
    chk1("wr_c3_pad_t", pad_t, 1'b1); chk1("wr_c3_stb", bus_stb, 1'b0); chk1("wr_c3_ready", req_ready, 1'b0);
    step(0, 0, 8'h00, 0, 8'h00); settle();
    chk1("wr_c4_ready", req_ready, 1'b1);

    // Read 0x3C, consumer always ready
    step(1, 0, 8'h00, 1, 8'h3C);
    for (int i = 1; i <= 2; i++) begin
      step(0, 0, 8'h00, 1, 8'h3C); settle();
      chk1("rd_stb", bus_stb, 1'b1); chk1("rd_pad_t", pad_t, 1'b1);
    end
    step(0, 0, 8'h00, 1, 8'h3C); settle();
    chk1("rd_c3_rv", rsp_valid, 1'b1); chk8("rd_c3_data", rsp_rdata, 8'h3C);
    step(0, 0, 8'h00, 1, 8'h3C); settle();
    chk1("rd_c4_rv", rsp_valid, 1'b0); chk1("rd_c4_pad_t", pad_t, 1'b1);
    step(0, 0, 8'h00, 1, 8'h3C); settle();
    chk1("rd_c5_ready", req_ready, 1'b1);

    // Read with stalled consumer while pad_o changes
    step(1, 0, 8'h00, 0, 8'h3C);
    step(0, 0, 8'h00, 0, 8'h3C);
    step(0, 0, 8'h00, 0, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 0, 8'hFF); settle();
      chk1("stall_rv", rsp_valid, 1'b1); chk8("stall_data", rsp_rdata, 8'h3C);
    end
    step(0, 0, 8'h00, 1, 8'hFF); settle();
    chk1("stall_hs_rv", rsp_valid, 1'b1);
    step(0, 0, 8'h00, 0, 8'hFF);
    step(0, 0, 8'h00, 0, 8'hFF);

    // Read followed by a write of 0x5A presented as early as possible
    step(1, 0, 8'h00, 1, 8'h77);
    step(0, 0, 8'h00, 1, 8'h77);
    step(0, 0, 8'h00, 1, 8'h77);
    step(1, 1, 8'h5A, 1, 8'h77); settle();
    chk1("b2b_hs_rv", rsp_valid, 1'b1); chk8("b2b_data", rsp_rdata, 8'h77);
    step(1, 1, 8'h5A, 1, 8'h77); settle();
    chk1("b2b_turn_pad_t", pad_t, 1'b1); chk1("b2b_turn_stb", bus_stb, 1'b0);
    step(1, 1, 8'h5A, 1, 8'h77); settle();
    chk1("b2b_idle_ready", req_ready, 1'b1);
    step(0, 0, 8'h00, 0, 8'h77); settle();
    chk1("b2b_drive_pad_t", pad_t, 1'b0); chk8("b2b_drive_pad_i", pad_i, 8'h5A);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 8'h00);

    // Reset during the first DRIVE cycle, then a complete write
    step(1, 1, 8'hC3, 0, 8'h00);
    step(0, 0, 8'h00, 0, 8'h00);
    async_reset("rst_drv");
    step(1, 1, 8'h96, 0, 8'h00);
    step(0, 0, 8'h00, 0, 8'h00); settle();
    chk1("post_rst_pad_t", pad_t, 1'b0); chk8("post_rst_pad_i", pad_i, 8'h96);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 2) != 0), 8'($urandom));
    end
    step(0, 0, 8'h00, 1, 8'h00);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
